mem_arbiter: RTL and testbench

//   Shares the single-port `memory` block between the core's instruction-fetch port (read-only)
//   and its data load/store port. Each requester holds a request until a one-cycle done pulse.
//   The arbiter registers one access at a time onto the memory port and returns read data.

---
 rtl/mem_arbiter.sv | 65 ++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port memory between fetch and data ports
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic [31:0]           i_rdata_o,
  output logic                  i_done_o,
  input  logic                  d_req_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [3:0]            d_wmask_i,
  input  logic [31:0]           d_wdata_i,
  output logic [31:0]           d_rdata_o,
  output logic                  d_done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rstrb_o,
  output logic [3:0]            mem_wmask_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {G_NONE, G_I, G_D} grant_t;
  state_t state, state_n;
  grant_t grant, grant_n;
  logic   last_d;
  logic   go, pick_d, is_load;
  assign go      = i_req_i | d_req_i;
  // On a tie the port that was not served last wins
  assign pick_d  = d_req_i & ~(i_req_i & last_d);
  assign is_load = ~pick_d | (d_wmask_i == 4'b0000);
  always_comb begin
    state_n = state == IDLE ? (go ? ISSUE : IDLE) : state == ISSUE ? RESP : IDLE;
    grant_n = state == IDLE ? (go ? (pick_d ? G_D : G_I) : G_NONE) : state == RESP ? G_NONE : grant;
  end
  assign i_done_o  = state == RESP && grant == G_I;
  assign d_done_o  = state == RESP && grant == G_D;
  assign i_rdata_o = mem_rdata_i;
  assign d_rdata_o = mem_rdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= G_NONE;
      last_d      <= 1'b1;
      mem_addr_o  <= '0;
      mem_rstrb_o <= 1'b0;
      mem_wmask_o <= 4'b0000;
      mem_wdata_o <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      if (state == IDLE && go) begin
        mem_addr_o  <= pick_d ? d_addr_i : i_addr_i;
        mem_rstrb_o <= is_load;
        mem_wmask_o <= pick_d ? d_wmask_i : 4'b0000;
        mem_wdata_o <= pick_d ? d_wdata_i : mem_wdata_o;
        last_d      <= pick_d;
      end else begin
        mem_rstrb_o <= 1'b0;
        mem_wmask_o <= 4'b0000;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter against a small registered-read memory model
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wmask = '0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, d_done, mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_done_o(i_done),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_wmask_i(d_wmask), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_done_o(d_done),
    .mem_addr_o(mem_addr), .mem_rstrb_o(mem_rstrb), .mem_wmask_o(mem_wmask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Memory model: registered read, byte-masked write, inert while in reset
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (!rst) begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h44; d_wmask = 0;
    tick(); tick();
    n_checks++; if ({mem_addr, mem_rstrb, mem_wmask, mem_wdata} !== 69'd0) begin n_fail++; $display("FAIL reset_mem: mem_* got %h want 0", {mem_addr, mem_rstrb, mem_wmask, mem_wdata}); end
    n_checks++; if ({i_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", {i_done, d_done}); end
    rst = 0;
    tick();
    n_checks++; if (mem_rstrb !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL first_tie_i: rstrb=%b addr=%h want 1/40", mem_rstrb, mem_addr); end
    tick();
    n_checks++; if ({i_done, d_done} !== 2'b10) begin n_fail++; $display("FAIL first_tie_done: got %b want 10", {i_done, d_done}); end
    i_req = 0;
    tick(); tick();
    n_checks++; if (mem_rstrb !== 1'b1 || mem_addr !== 32'h44) begin n_fail++; $display("FAIL second_d: rstrb=%b addr=%h want 1/44", mem_rstrb, mem_addr); end
    tick();
    n_checks++; if ({i_done, d_done} !== 2'b01) begin n_fail++; $display("FAIL second_d_done: got %b want 01", {i_done, d_done}); end
    d_req = 0;
    tick();
  endtask

  task automatic test_single_fetch();
    preload(6'd4, 32'hDEADBEEF);
    i_req = 1; i_addr = 32'h10;
    tick();
    n_checks++; if (mem_rstrb !== 1'b1 || mem_wmask !== 4'b0 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_issue: rstrb=%b wmask=%b addr=%h want 1/0000/10", mem_rstrb, mem_wmask, mem_addr); end
    n_checks++; if ({i_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL fetch_early_done: got %b want 00", {i_done, d_done}); end
    tick();
    n_checks++; if ({i_done, d_done} !== 2'b10) begin n_fail++; $display("FAIL fetch_done: got %b want 10", {i_done, d_done}); end
    n_checks++; if (i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h want deadbeef", i_rdata); end
    n_checks++; if (mem_rstrb !== 1'b0) begin n_fail++; $display("FAIL strobe_one_cycle: got %b want 0", mem_rstrb); end
    i_req = 0;
    tick();
    n_checks++; if (i_done !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got %b want 0", i_done); end
  endtask

  task automatic test_store_load();
    preload(6'd8, 32'h0);
    d_req = 1; d_addr = 32'h20; d_wmask = 4'b0011; d_wdata = 32'h1234ABCD;
    tick();
    n_checks++; if (mem_rstrb !== 1'b0 || mem_wmask !== 4'b0011 || mem_wdata !== 32'h1234ABCD || mem_addr !== 32'h20) begin n_fail++; $display("FAIL store_issue: rstrb=%b wmask=%b wdata=%h addr=%h", mem_rstrb, mem_wmask, mem_wdata, mem_addr); end
    tick();
    n_checks++; if ({i_done, d_done} !== 2'b01) begin n_fail++; $display("FAIL store_done: got %b want 01", {i_done, d_done}); end
    n_checks++; if (mem_wmask !== 4'b0) begin n_fail++; $display("FAIL wmask_one_cycle: got %b want 0000", mem_wmask); end
    d_req = 0;
    tick();
    d_req = 1; d_wmask = 4'b0000;
    tick();
    n_checks++; if (mem_rstrb !== 1'b1 || mem_wmask !== 4'b0) begin n_fail++; $display("FAIL load_issue: rstrb=%b wmask=%b want 1/0000", mem_rstrb, mem_wmask); end
    tick();
    n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0000ABCD) begin n_fail++; $display("FAIL load_rdata: done=%b data=%h want 1/0000abcd", d_done, d_rdata); end
    d_req = 0;
    tick();
  endtask

  task automatic test_contention();
    preload(6'd16, 32'h11110000);
    preload(6'd17, 32'h22220000);
    i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h44; d_wmask = 0;
    for (int k = 1; k <= 12; k++) begin
      logic ei, ed;
      tick();
      ei = (k % 3 == 2) && (((k - 2) / 3) % 2 == 0);
      ed = (k % 3 == 2) && (((k - 2) / 3) % 2 == 1);
      n_checks++; if ({i_done, d_done} !== {ei, ed}) begin n_fail++; $display("FAIL contention_done k=%0d: got %b want %b", k, {i_done, d_done}, {ei, ed}); end
      if (ei) begin
        n_checks++; if (i_rdata !== 32'h11110000) begin n_fail++; $display("FAIL contention_i_rdata k=%0d: got %h want 11110000", k, i_rdata); end
      end
      if (ed) begin
        n_checks++; if (d_rdata !== 32'h22220000) begin n_fail++; $display("FAIL contention_d_rdata k=%0d: got %h want 22220000", k, d_rdata); end
      end
    end
    i_req = 0; d_req = 0;
    tick();
    n_checks++; if (mem_rstrb !== 1'b0 || mem_wmask !== 4'b0) begin n_fail++; $display("FAIL contention_idle: rstrb=%b wmask=%b want 0/0000", mem_rstrb, mem_wmask); end
  endtask

  task automatic test_byte_mask();
    preload(6'd9, 32'h11223344);
    d_req = 1; d_addr = 32'h24; d_wmask = 4'b1000; d_wdata = 32'hAA000000;
    tick(); tick();
    n_checks++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL mask_store_done: got %b want 1", d_done); end
    d_req = 0;
    tick();
    d_req = 1; d_wmask = 4'b0000;
    tick(); tick();
    n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'hAA223344) begin n_fail++; $display("FAIL mask_reload: done=%b data=%h want 1/aa223344", d_done, d_rdata); end
    d_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    preload(6'd10, 32'h55667788);
    d_req = 1; d_addr = 32'h28; d_wmask = 4'b1111; d_wdata = 32'h0;
    tick();
    n_checks++; if (mem_wmask !== 4'b1111) begin n_fail++; $display("FAIL midrst_issue: wmask=%b want 1111", mem_wmask); end
    rst = 1;
    tick();
    n_checks++; if (d_done !== 1'b0 || {mem_addr, mem_rstrb, mem_wmask, mem_wdata} !== 69'd0) begin n_fail++; $display("FAIL midrst_state: done=%b mem_*=%h want 0/0", d_done, {mem_addr, mem_rstrb, mem_wmask, mem_wdata}); end
    rst = 0; d_req = 0;
    tick();
    n_checks++; if (d_done !== 1'b0 || mem_wmask !== 4'b0) begin n_fail++; $display("FAIL midrst_after: done=%b wmask=%b want 0/0000", d_done, mem_wmask); end
    n_checks++; if (mem[10] !== 32'h55667788) begin n_fail++; $display("FAIL midrst_mem: got %h want 55667788", mem[10]); end
    i_req = 1; i_addr = 32'h28;
    tick();
    n_checks++; if (mem_rstrb !== 1'b1 || mem_addr !== 32'h28) begin n_fail++; $display("FAIL midrst_idle: rstrb=%b addr=%h want 1/28", mem_rstrb, mem_addr); end
    tick();
    n_checks++; if (i_done !== 1'b1 || i_rdata !== 32'h55667788) begin n_fail++; $display("FAIL midrst_fetch: done=%b data=%h want 1/55667788", i_done, i_rdata); end
    i_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_byte_mask();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
